// File: rtl/ex_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl_if
// Bundle between the ID/EX hazard controller and the pipeline around it.
//   EX side : ex_exop, ex_fun, ex_fmt, ex_rwrite, ex_wbsrc, ex_dst
//   ID side : id_rs, id_rt, id_uses_rt
//   controls: stall_front, stall_idex, bubble_idex, bubble_exmem, fp_done
//   perf    : fp_stall_cycles, load_stall_cycles
// slave  = the hazard controller (consumes EX/ID fields, drives controls)
// master = the pipeline / testbench (drives EX/ID fields, observes controls)
// ----------------------------------------------------------------------------
interface ex_hazard_ctrl_if;
  logic [2:0]  ex_exop;
  logic [5:0]  ex_fun;
  logic [4:0]  ex_fmt;
  logic        ex_rwrite;
  logic [2:0]  ex_wbsrc;
  logic [4:0]  ex_dst;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;

  logic        stall_front;
  logic        stall_idex;
  logic        bubble_idex;
  logic        bubble_exmem;
  logic        fp_done;
  logic [31:0] fp_stall_cycles;
  logic [31:0] load_stall_cycles;

  modport master (
    output ex_exop, ex_fun, ex_fmt, ex_rwrite, ex_wbsrc, ex_dst,
    output id_rs, id_rt, id_uses_rt,
    input  stall_front, stall_idex, bubble_idex, bubble_exmem, fp_done,
    input  fp_stall_cycles, load_stall_cycles
  );

  modport slave (
    input  ex_exop, ex_fun, ex_fmt, ex_rwrite, ex_wbsrc, ex_dst,
    input  id_rs, id_rt, id_uses_rt,
    output stall_front, stall_idex, bubble_idex, bubble_exmem, fp_done,
    output fp_stall_cycles, load_stall_cycles
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
// Stall/bubble controller sitting on the consumer side of the ID/EX register.
//  - Multi-cycle FPU ops (mul/div/sqrt) are held in EX for their full latency
//    L: stalls + EX/MEM bubble for L-1 cycles, then one fp_done cycle.
//  - Load-use hazards get one cycle of front stall plus an ID/EX bubble.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset; all outputs forced 0 while low
//   bus    : ex_hazard_ctrl_if.slave (EX/ID fields in, controls/perf out)
// Build option:
//   HAZARD_PERF_COUNT_EN : when defined, fp_stall_cycles / load_stall_cycles
//   are saturating counters; otherwise both read 0 and no flops exist.
// ----------------------------------------------------------------------------
module ex_hazard_ctrl #(
  parameter int unsigned FP_MUL_LAT  = 4,
  parameter int unsigned FP_DIV_LAT  = 12,
  parameter int unsigned FP_SQRT_LAT = 16,
  parameter int unsigned DBL_EXTRA   = 3,
  parameter logic [2:0]  FPU_EXOP    = 3'd4,
  parameter logic [2:0]  LOAD_WBSRC  = 3'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_hazard_ctrl_if.slave    bus
);

  typedef enum logic {IDLE, FP_BUSY} state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  logic       fp_trig;
  logic [4:0] fp_lat;
  logic       load_use;

  logic       stall_front_c, stall_idex_c, bubble_idex_c, bubble_exmem_c, fp_done_c;

  // Latency decode for the op in EX; only mul/div/sqrt are multi-cycle.
  always_comb begin
    fp_trig = 1'b0;
    fp_lat  = 5'd0;
    if (bus.ex_exop == FPU_EXOP) begin
      case (bus.ex_fun)
        6'h02:   begin fp_trig = 1'b1; fp_lat = 5'(FP_MUL_LAT);  end
        6'h03:   begin fp_trig = 1'b1; fp_lat = 5'(FP_DIV_LAT);  end
        6'h04:   begin fp_trig = 1'b1; fp_lat = 5'(FP_SQRT_LAT); end
        default: begin fp_trig = 1'b0; fp_lat = 5'd0;            end
      endcase
    end
    if (bus.ex_fmt == 5'h11)
      fp_lat = fp_lat + 5'(DBL_EXTRA);
  end

  // A load still in EX whose destination is read by ID; $0 is never a hazard.
  assign load_use = bus.ex_rwrite && (bus.ex_wbsrc == LOAD_WBSRC) &&
                    (bus.ex_dst != 5'd0) &&
                    ((bus.ex_dst == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_dst == bus.id_rt)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_front_c  = 1'b0;
    stall_idex_c   = 1'b0;
    bubble_idex_c  = 1'b0;
    bubble_exmem_c = 1'b0;
    fp_done_c      = 1'b0;
    case (state_q)
      IDLE: begin
        // FP trigger wins over load-use if decode ever lets both through.
        if (fp_trig) begin
          stall_front_c  = 1'b1;
          stall_idex_c   = 1'b1;
          bubble_exmem_c = 1'b1;
          state_d        = FP_BUSY;
          // Trigger cycle counts as the first of L; the done cycle is the last.
          cnt_d          = fp_lat - 5'd2;
        end else if (load_use) begin
          stall_front_c  = 1'b1;
          bubble_idex_c  = 1'b1;
        end
      end
      FP_BUSY: begin
        if (cnt_q != 5'd0) begin
          stall_front_c  = 1'b1;
          stall_idex_c   = 1'b1;
          bubble_exmem_c = 1'b1;
          cnt_d          = cnt_q - 5'd1;
        end else begin
          // Result cycle: release the pipe so the op leaves EX at this edge,
          // which is what prevents it from re-triggering.
          fp_done_c      = 1'b1;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  assign bus.stall_front  = rst_n & stall_front_c;
  assign bus.stall_idex   = rst_n & stall_idex_c;
  assign bus.bubble_idex  = rst_n & bubble_idex_c;
  assign bus.bubble_exmem = rst_n & bubble_exmem_c;
  assign bus.fp_done      = rst_n & fp_done_c;

`ifdef HAZARD_PERF_COUNT_EN
  logic [31:0] fp_stall_q, load_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fp_stall_q   <= 32'h0;
      load_stall_q <= 32'h0;
    end else begin
      if (stall_idex_c && (fp_stall_q != 32'hFFFF_FFFF))
        fp_stall_q <= fp_stall_q + 32'h1;
      if (bubble_idex_c && (load_stall_q != 32'hFFFF_FFFF))
        load_stall_q <= load_stall_q + 32'h1;
    end
  end

  assign bus.fp_stall_cycles   = rst_n ? fp_stall_q   : 32'h0;
  assign bus.load_stall_cycles = rst_n ? load_stall_q : 32'h0;
`else
  assign bus.fp_stall_cycles   = 32'h0;
  assign bus.load_stall_cycles = 32'h0;
`endif

endmodule
